arb2_stream: RTL
================

ARB2_STREAM -- requirements
Module: arb2_stream

Interface
REQ-001 Parameter: WIDTH, 8, data width of each stream in bits (legal range 1..64).
REQ-002 Port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 Port: i0_valid  input  1  stream 0 word available.
REQ-005 Port: i0_data  input  WIDTH  stream 0 word.
REQ-006 Port: i0_ready  output  1  stream 0 word accepted this cycle when high with i0_valid.
REQ-007 Port: i1_valid  input  1  stream 1 word available.
REQ-008 Port: i1_data  input  WIDTH  stream 1 word.
REQ-009 Port: i1_ready  output  1  stream 1 word accepted this cycle when high with i1_valid.
REQ-010 Port: o_valid  output  1  output register holds a word.
REQ-011 Port: o_ready  input  1  downstream consumes the word when high with o_valid.
REQ-012 Port: o_data  output  WIDTH  registered selected word.
REQ-013 Port: o_src  output  1  source of the word in o_data: 0 = stream 0, 1 = stream 1.

Function
REQ-014 Transfer on any port SHALL occur exactly when valid and ready are both high at a rising clk edge.
REQ-015 load_en SHALL equal (!o_valid | o_ready); the output register SHALL accept a new word only when load_en is high.
REQ-016 Grant: only one valid -> that input; both valid -> input not recorded in last; neither -> no grant.
REQ-017 iN_ready SHALL be load_en AND grant_N; at most one of i0_ready/i1_ready SHALL be high in any cycle.
REQ-018 Ready SHALL depend only on valids, last, o_valid and o_ready; no combinational path from iN_data to any ready.
REQ-019 On a grant with load_en: o_data <= granted data, o_src <= granted index, o_valid <= 1, last <= granted index; latency input-to-output is exactly 1 cycle.
REQ-020 No grant while load_en high SHALL set o_valid <= 0; when load_en low, o_data, o_src, o_valid, last SHALL hold.
REQ-021 Simultaneous drain and load (o_valid & o_ready & grant) SHALL sustain one word per cycle with no bubble.
REQ-022 Both inputs continuously valid with o_ready high SHALL alternate grants 0,1,0,1,...; each input is served within 2 output transfers (starvation bound).
REQ-023 Input valid dropping without a transfer SHALL not update last or any output state.
REQ-024 State machine, two states: EMPTY (o_valid=0) and FULL (o_valid=1); EMPTY->FULL on grant; FULL->EMPTY on o_ready with no grant; FULL->FULL on stall or drain+grant.

Reset
REQ-025 While rst_n low: o_valid=0, o_data=0, o_src=0, last=1, i0_ready=0, i1_ready=0.
REQ-026 Reset asserted mid-transfer SHALL discard the held word immediately; first grant after release with both valid SHALL go to stream 0.
REQ-027 Reset deassertion is synchronised externally; the block SHALL not accept a word in the cycle rst_n is low.

Structure
REQ-028 Package arb2_pkg SHALL hold WIDTH default (8) and source encodings SRC_I0=0, SRC_I1=1.
REQ-029 Data selection SHALL use the existing mux2x1 cell, one instance per bit, select driven by the grant index.
REQ-030 Grant and last-pointer logic SHALL be one always block; no further sub-modules.

Verification
REQ-031 Reset: hold rst_n=0 with i0_valid=i1_valid=1 -> o_valid=0, o_data=0, both readies 0.
REQ-032 Single stream: i0 sends 0x11,0x22,0x33 back-to-back, o_ready=1 -> o_data 0x11,0x22,0x33 on consecutive cycles, o_src=0, 1-cycle latency.
REQ-033 Contention: both valid, i0 0xA0.., i1 0xB0.., o_ready=1 -> outputs 0xA0,0xB0,0xA1,0xB1, o_src 0,1,0,1.
REQ-034 Backpressure: o_valid=1 with 0x5A, o_ready=0 for 3 cycles -> o_data stays 0x5A, both readies 0, no input consumed.
REQ-035 Drain to empty: last word 0x7F taken with o_ready=1, no inputs valid -> o_valid=0 next cycle.
REQ-036 Mid-op reset: pulse rst_n low while o_valid=1 -> o_valid=0 asynchronously; then both valid -> first output from stream 0.

Source files
------------

// File: rtl/arb2_pkg.sv
// Shared constants for the two-input round-robin stream arbiter:
// default data width, source index encodings and output FSM state codes.
package arb2_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic SRC_I0 = 1'b0;
  localparam logic SRC_I1 = 1'b1;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  // Tie-break: on contention, serve the stream that was not served last.
  function automatic logic tie_winner(input logic last_src);
    return ~last_src;
  endfunction

endpackage

// File: rtl/mux2x1.sv
// Library 2:1 single-bit multiplexer cell: y = sel ? b : a.
module mux2x1 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/arb2_stream.sv
// Two-input valid/ready arbiter with round-robin tie-break feeding a single
// registered output stage; one word per cycle sustained under contention.
module arb2_stream
  import arb2_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i0_valid,
  input  logic [WIDTH-1:0] i0_data,
  output logic             i0_ready,
  input  logic             i1_valid,
  input  logic [WIDTH-1:0] i1_data,
  output logic             i1_ready,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_src
);

  logic [0:0]       state_reg;
  logic [0:0]       state_next;
  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] data_next;
  logic             src_reg;
  logic             src_next;
  logic             last_reg;
  logic             last_next;

  logic             load_en;
  logic             grant_any;
  logic             grant_idx;
  logic [WIDTH-1:0] sel_data;

  assign o_valid = (state_reg == ST_FULL);
  assign o_data  = data_reg;
  assign o_src   = src_reg;

  // The output stage can take a word when empty or when its word leaves now.
  assign load_en = ~o_valid | o_ready;

  // Grant and round-robin pointer: last only moves on an actual transfer.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = SRC_I0;
    last_next = last_reg;
    if (i0_valid && i1_valid) begin
      grant_any = 1'b1;
      grant_idx = tie_winner(last_reg);
    end else if (i0_valid) begin
      grant_any = 1'b1;
      grant_idx = SRC_I0;
    end else if (i1_valid) begin
      grant_any = 1'b1;
      grant_idx = SRC_I1;
    end
    if (load_en && grant_any) begin
      last_next = grant_idx;
    end
  end

  // Readies are forced low while reset is held so nothing is accepted then.
  assign i0_ready = rst_n & load_en & grant_any & (grant_idx == SRC_I0);
  assign i1_ready = rst_n & load_en & grant_any & (grant_idx == SRC_I1);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sel
      mux2x1 u_mux (
        .a   (i0_data[gi]),
        .b   (i1_data[gi]),
        .sel (grant_idx),
        .y   (sel_data[gi])
      );
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    src_next   = src_reg;
    case (state_reg)
      ST_EMPTY: begin
        if (grant_any) begin
          state_next = ST_FULL;
          data_next  = sel_data;
          src_next   = grant_idx;
        end
      end
      ST_FULL: begin
        if (o_ready) begin
          if (grant_any) begin
            data_next = sel_data;
            src_next  = grant_idx;
          end else begin
            state_next = ST_EMPTY;
          end
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_EMPTY;
      data_reg  <= '0;
      src_reg   <= SRC_I0;
      last_reg  <= SRC_I1;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      src_reg   <= src_next;
      last_reg  <= last_next;
    end
  end

endmodule
